// File: rtl/datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the datapath sequencer. It holds the op codes, the
// sequencer state enumeration, the ALU function-select (fs) codes, the
// instruction field positions and the control word that the decoder produces.
// Instruction layout: {op[31:28], rd[27:23], rn[22:18], rm[17:13], imm[12:0]}.
// -----------------------------------------------------------------------------
package datapath_pkg;

  localparam int INSTR_W = 32;
  localparam int K_W     = 64;
  localparam int ADDR_W  = 5;
  localparam int FS_W    = 5;

  // Field bit positions.
  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 28;
  localparam int RD_MSB  = 27;
  localparam int RD_LSB  = 23;
  localparam int RN_MSB  = 22;
  localparam int RN_LSB  = 18;
  localparam int RM_MSB  = 17;
  localparam int RM_LSB  = 13;
  localparam int IMM_MSB = 12;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  // Op codes; 9..15 are illegal.
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_ORR  = 4'd3;
  localparam logic [3:0] OP_ADDI = 4'd4;
  localparam logic [3:0] OP_SUBI = 4'd5;
  localparam logic [3:0] OP_LDR  = 4'd6;
  localparam logic [3:0] OP_STR  = 4'd7;
  localparam logic [3:0] OP_MOVI = 4'd8;

  // ALU function-select encoding.
  localparam logic [FS_W-1:0] FS_AND = 5'b00000;
  localparam logic [FS_W-1:0] FS_ORR = 5'b00100;
  localparam logic [FS_W-1:0] FS_ADD = 5'b01000;
  localparam logic [FS_W-1:0] FS_SUB = 5'b01001;

  // Register 31 reads as zero.
  localparam logic [ADDR_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MEM  = 2'd2
  } state_e;

  // Full datapath control word, one per cycle.
  typedef struct packed {
    logic [K_W-1:0]    k;
    logic [ADDR_W-1:0] reg_addr;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [FS_W-1:0]   fs;
    logic              reg_w;
    logic              b_sel;
    logic              b_en;
    logic              alu_en;
    logic              mem_en;
    logic              chip_sel;
    logic              mem_w;
    logic              mem_r;
    logic              stat_en;
    logic              c0;
    logic              illegal;
  } ctrl_t;

  function automatic logic [3:0] f_op(input logic [INSTR_W-1:0] i);
    return i[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] f_rd(input logic [INSTR_W-1:0] i);
    return i[RD_MSB:RD_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] f_rn(input logic [INSTR_W-1:0] i);
    return i[RN_MSB:RN_LSB];
  endfunction

  function automatic logic [ADDR_W-1:0] f_rm(input logic [INSTR_W-1:0] i);
    return i[RM_MSB:RM_LSB];
  endfunction

  function automatic logic [IMM_W-1:0] f_imm(input logic [INSTR_W-1:0] i);
    return i[IMM_MSB:IMM_LSB];
  endfunction

  // Loads and stores need the extra MEM cycle.
  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_LDR) || (op == OP_STR);
  endfunction

  // fs for the arithmetic/logic ops; everything else adds.
  function automatic logic [FS_W-1:0] alu_fs(input logic [3:0] op);
    case (op)
      OP_SUB, OP_SUBI: return FS_SUB;
      OP_AND:          return FS_AND;
      OP_ORR:          return FS_ORR;
      default:         return FS_ADD;
    endcase
  endfunction

endpackage

// File: rtl/seq_decode.sv
// -----------------------------------------------------------------------------
// seq_decode
// Purely combinational op-to-control-word decoder. Given the phase the
// sequencer is about to enter and the instruction being executed, it returns
// the control word for that cycle. Any phase other than EXEC/MEM yields an
// all-zero word.
//
// Optional feature: `SEQ_FLAG_SET_EN. When defined, ADD/SUB with imm[0]=1
// become ADDS/SUBS and raise stat_en in EXEC; otherwise stat_en is tied 0.
//
// Ports:
//   phase_i  state whose control word is requested (the next state)
//   instr_i  instruction word
//   ctrl_o   control word for that state
// -----------------------------------------------------------------------------
module seq_decode
  import datapath_pkg::*;
(
  input  state_e             phase_i,
  input  logic [INSTR_W-1:0] instr_i,
  output ctrl_t              ctrl_o
);

  logic [3:0]        op;
  logic [ADDR_W-1:0] rd;
  logic [ADDR_W-1:0] rn;
  logic [ADDR_W-1:0] rm;
  logic [IMM_W-1:0]  imm;
  logic [K_W-1:0]    imm_k;

  assign op    = f_op(instr_i);
  assign rd    = f_rd(instr_i);
  assign rn    = f_rn(instr_i);
  assign rm    = f_rm(instr_i);
  assign imm   = f_imm(instr_i);
  assign imm_k = {{(K_W-IMM_W){1'b0}}, imm};

  always_comb begin
    ctrl_o = '0;
    case (phase_i)
      ST_EXEC: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
            ctrl_o.a_addr   = rn;
            ctrl_o.b_addr   = rm;
            ctrl_o.fs       = alu_fs(op);
            ctrl_o.alu_en   = 1'b1;
            ctrl_o.reg_w    = 1'b1;
            ctrl_o.reg_addr = rd;
`ifdef SEQ_FLAG_SET_EN
            // ADDS/SUBS: imm[0] requests a flag update alongside the op.
            if ((op == OP_ADD || op == OP_SUB) && imm[0]) begin
              ctrl_o.stat_en = 1'b1;
            end
`else
            ctrl_o.stat_en  = 1'b0;
`endif
          end
          OP_ADDI, OP_SUBI: begin
            ctrl_o.a_addr   = rn;
            ctrl_o.b_addr   = rm;
            ctrl_o.b_sel    = 1'b1;
            ctrl_o.k        = imm_k;
            ctrl_o.fs       = alu_fs(op);
            ctrl_o.alu_en   = 1'b1;
            ctrl_o.reg_w    = 1'b1;
            ctrl_o.reg_addr = rd;
          end
          OP_MOVI: begin
            // rd = XZR + imm
            ctrl_o.a_addr   = XZR;
            ctrl_o.b_sel    = 1'b1;
            ctrl_o.k        = imm_k;
            ctrl_o.fs       = FS_ADD;
            ctrl_o.alu_en   = 1'b1;
            ctrl_o.reg_w    = 1'b1;
            ctrl_o.reg_addr = rd;
          end
          OP_LDR, OP_STR: begin
            // Address generation: rn + imm, latched by the memory stage.
            ctrl_o.a_addr = rn;
            ctrl_o.b_sel  = 1'b1;
            ctrl_o.k      = imm_k;
            ctrl_o.fs     = FS_ADD;
            ctrl_o.alu_en = 1'b1;
            ctrl_o.mem_en = 1'b1;
          end
          default: begin
            ctrl_o.illegal = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        if (op == OP_LDR) begin
          ctrl_o.chip_sel = 1'b1;
          ctrl_o.mem_r    = 1'b1;
          ctrl_o.reg_w    = 1'b1;
          ctrl_o.reg_addr = rd;
        end else if (op == OP_STR) begin
          // Store data comes from rd through the B port onto the d-bus.
          ctrl_o.b_addr = rd;
          ctrl_o.b_en   = 1'b1;
          ctrl_o.mem_w  = 1'b1;
        end
      end
      default: begin
        ctrl_o = '0;
      end
    endcase
    // Carry-in is the +1 of the two's-complement subtract.
    ctrl_o.c0 = ctrl_o.alu_en && (ctrl_o.fs == FS_SUB);
  end

endmodule

// File: rtl/datapath_sequencer.sv
// -----------------------------------------------------------------------------
// datapath_sequencer
// Moore FSM (IDLE -> EXEC [-> MEM] -> IDLE) that issues one registered
// datapath control word per cycle. An instruction is accepted when
// instr_valid and instr_ready are high at a rising edge; ALU/MOVI/illegal ops
// occupy one EXEC cycle, LDR/STR add a MEM cycle. Every output is a flop; the
// word for the coming state is decoded one cycle ahead from that state.
//
// Optional feature: `SEQ_FLAG_SET_EN (see seq_decode) enables ADDS/SUBS.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   instr, instr_valid       instruction and its valid
//   instr_ready              high only in IDLE
//   status                   datapath flags {v, c, n, z, z_imm}
//   k, reg_addr, a_addr, b_addr, fs, reg_w, b_sel, b_en, alu_en, mem_en,
//   chip_sel, mem_w, mem_r, stat_en, c0   datapath control word
//   busy                     high in EXEC and MEM
//   illegal                  one-cycle pulse in EXEC for op 9..15
// -----------------------------------------------------------------------------
module datapath_sequencer
  import datapath_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [4:0]         status,
  output logic [K_W-1:0]     k,
  output logic [ADDR_W-1:0]  reg_addr,
  output logic [ADDR_W-1:0]  a_addr,
  output logic [ADDR_W-1:0]  b_addr,
  output logic [FS_W-1:0]    fs,
  output logic               reg_w,
  output logic               b_sel,
  output logic               b_en,
  output logic               alu_en,
  output logic               mem_en,
  output logic               chip_sel,
  output logic               mem_w,
  output logic               mem_r,
  output logic               stat_en,
  output logic               c0,
  output logic               busy,
  output logic               illegal
);

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  ctrl_t              ctrl_q, ctrl_d;
  ctrl_t              dec_ctrl;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               transfer;
  logic [INSTR_W-1:0] dec_instr;

  // The flags are consumed by the datapath itself when stat_en is raised;
  // the sequencer never branches on them.
  logic unused_status;
  assign unused_status = ^status;

  assign transfer = instr_valid && ready_q;

  // In IDLE the word being decoded is the one arriving on the bus; afterwards
  // it is the latched copy.
  assign dec_instr = (state_q == ST_IDLE) ? instr : instr_q;
  assign instr_d   = transfer ? instr : instr_q;

  seq_decode u_decode (
    .phase_i (state_d),
    .instr_i (dec_instr),
    .ctrl_o  (dec_ctrl)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
      ctrl_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      ctrl_q  <= ctrl_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (transfer) state_d = ST_EXEC;
      ST_EXEC: state_d = op_is_mem(f_op(instr_q)) ? ST_MEM : ST_IDLE;
      ST_MEM:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: the word for the state being entered.
  always_comb begin
    ctrl_d  = dec_ctrl;
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  assign instr_ready = ready_q;
  assign busy        = busy_q;
  assign k           = ctrl_q.k;
  assign reg_addr    = ctrl_q.reg_addr;
  assign a_addr      = ctrl_q.a_addr;
  assign b_addr      = ctrl_q.b_addr;
  assign fs          = ctrl_q.fs;
  assign reg_w       = ctrl_q.reg_w;
  assign b_sel       = ctrl_q.b_sel;
  assign b_en        = ctrl_q.b_en;
  assign alu_en      = ctrl_q.alu_en;
  assign mem_en      = ctrl_q.mem_en;
  assign chip_sel    = ctrl_q.chip_sel;
  assign mem_w       = ctrl_q.mem_w;
  assign mem_r       = ctrl_q.mem_r;
  assign stat_en     = ctrl_q.stat_en;
  assign c0          = ctrl_q.c0;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_datapath_sequencer.sv
// -----------------------------------------------------------------------------
// tb_datapath_sequencer
// Table of instructions with their expected EXEC/MEM control words; each
// accepted instruction pushes its expected per-cycle words to a queue, and a
// monitor on the falling edge pops and compares them (or checks the idle word
// when nothing is pending). Hand-written sequences cover instr_valid held
// high while busy and reset in the middle of an LDR.
// -----------------------------------------------------------------------------
module tb_datapath_sequencer;
  import datapath_pkg::*;

  logic              clk;
  logic              rst;
  logic [31:0]       instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [4:0]        status;
  logic [63:0]       k;
  logic [4:0]        reg_addr, a_addr, b_addr, fs;
  logic              reg_w, b_sel, b_en, alu_en, mem_en, chip_sel;
  logic              mem_w, mem_r, stat_en, c0, busy, illegal;

  datapath_sequencer dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .status(status), .k(k), .reg_addr(reg_addr),
    .a_addr(a_addr), .b_addr(b_addr), .fs(fs), .reg_w(reg_w), .b_sel(b_sel),
    .b_en(b_en), .alu_en(alu_en), .mem_en(mem_en), .chip_sel(chip_sel),
    .mem_w(mem_w), .mem_r(mem_r), .stat_en(stat_en), .c0(c0), .busy(busy),
    .illegal(illegal)
  );

  typedef struct packed {
    logic [63:0] k;
    logic [4:0]  reg_addr, a_addr, b_addr, fs;
    logic        reg_w, b_sel, b_en, alu_en, mem_en, chip_sel;
    logic        mem_w, mem_r, stat_en, c0, illegal, busy, instr_ready;
  } obs_t;

  typedef struct {
    string name;
    logic [31:0] instr;
    obs_t exp_exec;
    obs_t exp_mem;
    bit   has_mem;
  } vec_t;

  typedef struct {
    string name;
    obs_t  o;
  } exp_t;

  obs_t cur;
  assign cur = {k, reg_addr, a_addr, b_addr, fs, reg_w, b_sel, b_en, alu_en,
                mem_en, chip_sel, mem_w, mem_r, stat_en, c0, illegal, busy,
                instr_ready};

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  int   cyc    = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mk(logic [3:0] op, logic [4:0] rd, logic [4:0] rn,
                                     logic [4:0] rm, logic [12:0] imm);
    return {op, rd, rn, rm, imm};
  endfunction

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.instr_ready = 1'b1;
    return o;
  endfunction

  function automatic obs_t busy_obs();
    obs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  // EXEC word of a register-writing ALU operation.
  function automatic obs_t ex_alu(logic [4:0] rd, logic [4:0] a, logic [4:0] b,
                                  logic [4:0] f, logic bsel, logic cin,
                                  logic [12:0] kimm, logic st);
    obs_t o = busy_obs();
    o.reg_addr = rd;
    o.a_addr   = a;
    o.b_addr   = b;
    o.fs       = f;
    o.b_sel    = bsel;
    o.c0       = cin;
    o.k        = {51'b0, kimm};
    o.alu_en   = 1'b1;
    o.reg_w    = 1'b1;
    o.stat_en  = st;
    return o;
  endfunction

  function automatic obs_t ex_addr(logic [4:0] rn, logic [12:0] kimm);
    obs_t o = busy_obs();
    o.a_addr = rn;
    o.b_sel  = 1'b1;
    o.k      = {51'b0, kimm};
    o.fs     = FS_ADD;
    o.alu_en = 1'b1;
    o.mem_en = 1'b1;
    return o;
  endfunction

  // Monitor: scoreboard compare plus single-bus-driver check every cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mon_en && rst) begin
      exp_t e;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else begin
        e.name = "idle";
        e.o    = idle_obs();
      end
      checks++;
      if (cur !== e.o) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, cur, e.o);
      end else begin
        $display("ok   %s: %h", e.name, cur);
      end
      checks++;
      if ($countones({b_en, alu_en, chip_sel}) > 1) begin
        errors++;
        $display("FAIL bus_driver: got b_en/alu_en/chip_sel=%b expected at most one", {b_en, alu_en, chip_sel});
      end
    end
  end

  task automatic wait_ready(string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_ready && n < 20);
    if (!instr_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got instr_ready=0 expected 1 within 20 cycles", name);
    end
  endtask

  task automatic send(vec_t v);
    exp_t e;
    wait_ready(v.name);
    #1;
    instr       = v.instr;
    instr_valid = 1'b1;
    e.name = {v.name, "_exec"};
    e.o    = v.exp_exec;
    exp_q.push_back(e);
    if (v.has_mem) begin
      e.name = {v.name, "_mem"};
      e.o    = v.exp_mem;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  vec_t vecs[15];
  bit   flag_en;

  initial begin
    obs_t o;
    exp_t e;
    vec_t v;
`ifdef SEQ_FLAG_SET_EN
    flag_en = 1'b1;
`else
    flag_en = 1'b0;
`endif
    rst = 0; instr = '0; instr_valid = 0; status = 5'b10101;

    vecs[0]  = '{"addi", mk(OP_ADDI, 3, 31, 0, 5),
                 ex_alu(3, 31, 0, FS_ADD, 1, 0, 13'd5, 0), '0, 0};
    vecs[1]  = '{"sub", mk(OP_SUB, 2, 1, 4, 0),
                 ex_alu(2, 1, 4, FS_SUB, 0, 1, 13'd0, 0), '0, 0};
    vecs[2]  = '{"add", mk(OP_ADD, 9, 10, 11, 0),
                 ex_alu(9, 10, 11, FS_ADD, 0, 0, 13'd0, 0), '0, 0};
    vecs[3]  = '{"and", mk(OP_AND, 1, 2, 3, 0),
                 ex_alu(1, 2, 3, FS_AND, 0, 0, 13'd0, 0), '0, 0};
    vecs[4]  = '{"orr", mk(OP_ORR, 31, 30, 29, 0),
                 ex_alu(31, 30, 29, FS_ORR, 0, 0, 13'd0, 0), '0, 0};
    vecs[5]  = '{"subi", mk(OP_SUBI, 4, 5, 0, 13'h1FFF),
                 ex_alu(4, 5, 0, FS_SUB, 1, 1, 13'h1FFF, 0), '0, 0};
    vecs[6]  = '{"movi", mk(OP_MOVI, 6, 17, 0, 13'h1234),
                 ex_alu(6, 31, 0, FS_ADD, 1, 0, 13'h1234, 0), '0, 0};
    o = busy_obs(); o.chip_sel = 1; o.mem_r = 1; o.reg_w = 1; o.reg_addr = 7;
    vecs[7]  = '{"ldr", mk(OP_LDR, 7, 0, 0, 8), ex_addr(0, 13'd8), o, 1};
    o = busy_obs(); o.b_addr = 5; o.b_en = 1; o.mem_w = 1;
    vecs[8]  = '{"str", mk(OP_STR, 5, 3, 0, 20), ex_addr(3, 13'd20), o, 1};
    o = busy_obs(); o.illegal = 1;
    vecs[9]  = '{"ill12", mk(4'd12, 1, 2, 3, 7), o, '0, 0};
    vecs[10] = '{"ill9", mk(4'd9, 0, 0, 0, 0), o, '0, 0};
    vecs[11] = '{"ill15", mk(4'd15, 31, 31, 31, 13'h1FFF), o, '0, 0};
    vecs[12] = '{"subs", mk(OP_SUB, 8, 9, 10, 1),
                 ex_alu(8, 9, 10, FS_SUB, 0, 1, 13'd0, flag_en), '0, 0};
    vecs[13] = '{"adds", mk(OP_ADD, 8, 9, 10, 3),
                 ex_alu(8, 9, 10, FS_ADD, 0, 0, 13'd0, flag_en), '0, 0};
    vecs[14] = '{"addi_imm1", mk(OP_ADDI, 12, 13, 0, 1),
                 ex_alu(12, 13, 0, FS_ADD, 1, 0, 13'd1, 0), '0, 0};

    // Reset state (instr_ready is free during reset itself).
    #3;
    o = cur; o.instr_ready = 1'b0;
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected all zero", o);
    end else $display("ok   reset_state");
    #9 rst = 1;
    #1 mon_en = 1;

    foreach (vecs[i]) send(vecs[i]);

    // instr_valid held high through EXEC must not start a second transfer.
    wait_ready("hold");
    #1;
    instr = mk(OP_ADD, 1, 2, 3, 0); instr_valid = 1;
    e.name = "hold_add_exec"; e.o = ex_alu(1, 2, 3, FS_ADD, 0, 0, 13'd0, 0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    instr = mk(OP_MOVI, 4, 0, 0, 13'd99);
    @(negedge clk);  // EXEC of ADD
    @(negedge clk);  // back in IDLE, MOVI still offered
    #1;
    e.name = "hold_movi_exec"; e.o = ex_alu(4, 31, 0, FS_ADD, 1, 0, 13'd99, 0);
    exp_q.push_back(e);
    @(posedge clk); #1;
    instr_valid = 0;

    // Reset during LDR EXEC: outputs clear at once, no MEM cycle follows.
    wait_ready("rst_ldr");
    #1;
    instr = mk(OP_LDR, 7, 0, 0, 8); instr_valid = 1;
    e.name = "rst_ldr_exec"; e.o = ex_addr(0, 13'd8);
    exp_q.push_back(e);
    @(posedge clk); #1;
    instr_valid = 0;
    @(negedge clk);
    #2 rst = 0;
    #1;
    o = cur; o.instr_ready = 1'b0;
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL rst_mid_ldr: got %h expected all zero", o);
    end else $display("ok   rst_mid_ldr");
    #1 rst = 1;

    // One more instruction after the abandoned load.
    v = '{"post_rst_sub", mk(OP_SUBI, 2, 2, 0, 1),
          ex_alu(2, 2, 0, FS_SUB, 1, 1, 13'd1, 0), '0, 0};
    send(v);

    repeat (4) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100us");
    $fatal(1, "timeout");
  end

endmodule
